// File: rtl/median_frame_sink_if.sv
// Filtered pixel beat from the 2x2 median filter.
// No backpressure: the producer streams one beat per valid.
interface pixel_valid_if;
  logic [23:0] pixel;
  logic        valid;

  modport master (output pixel, output valid);
  modport slave  (input  pixel, input  valid);
endinterface

// File: rtl/median_frame_sink.sv
// Sink after the 2x2 median: drops row 0 / column 0 beats,
// buffers kept pixels in a FWFT FIFO with sof/eol/eof tags.
module median_frame_sink #(
  parameter int IMAGE_LEN    = 1080,
  parameter int IMAGE_HEIGHT = 720,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  pixel_valid_if.slave  pixel_valid_if_i,
  output logic [23:0]   pixel_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          sof_o,
  output logic          eol_o,
  output logic          eof_o,
  output logic          done_o,
  output logic          overflow_o
);

  localparam int XW = (IMAGE_LEN > 2) ? $clog2(IMAGE_LEN) : 1;
  localparam int YW = (IMAGE_HEIGHT > 2) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_LEN - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic        eof;
    logic        eol;
    logic        sof;
    logic [23:0] pixel;
  } word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t         state;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;

  word_t          mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  logic  beat_in;
  logic  keep;
  logic  empty;
  logic  full;
  logic  pop;
  logic  push;
  logic  drop;
  word_t wr_word;
  word_t rd_word;

  always_comb begin
    beat_in = (state == RUN) && pixel_valid_if_i.valid;
    keep    = beat_in && (x != '0) && (y != '0);
    empty   = (count == '0);
    full    = (count == FULL_CNT);
    pop     = !empty && ready_i;
    // A full FIFO still takes a beat when a pop frees a slot.
    push    = keep && (!full || pop);
    drop    = keep && full && !pop;

    wr_word.pixel = pixel_valid_if_i.pixel;
    wr_word.sof   = (x == XW'(1)) && (y == YW'(1));
    wr_word.eol   = (x == X_LAST);
    wr_word.eof   = (x == X_LAST) && (y == Y_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      done_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state      <= RUN;
            x          <= '0;
            y          <= '0;
            overflow_o <= 1'b0;
          end
        end
        RUN: begin
          if (beat_in) begin
            if (x == X_LAST) begin
              x <= '0;
              if (y == Y_LAST) begin
                y     <= '0;
                state <= DRAIN;
              end else begin
                y <= y + YW'(1);
              end
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        DRAIN: begin
          if (empty) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (drop) overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; reads are masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_word;
  end

  always_comb begin
    rd_word = empty ? '0 : mem[rd_ptr];
    valid_o = !empty;
    pixel_o = rd_word.pixel;
    sof_o   = rd_word.sof;
    eol_o   = rd_word.eol;
    eof_o   = rd_word.eof;
  end

endmodule
